// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU encodings, widths and arbiter state type
package alu_pkg;

  localparam int XLEN        = 32;
  localparam int ALU_OP_W    = 4;
  localparam int ALU_OP_LAST = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD_IMM = 4'd0,
    ALU_SUB     = 4'd1,
    ALU_AND     = 4'd2,
    ALU_OR      = 4'd3,
    ALU_XOR     = 4'd4,
    ALU_ADD     = 4'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_ex.sv
// rtl/alu_ex.sv - combinational EX ALU, undefined encodings produce zero
module alu_ex
  import alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [XLEN-1:0]     rs1,
  input  logic [XLEN-1:0]     rs2,
  input  logic [XLEN-1:0]     imm,
  output logic [XLEN-1:0]     alu_result
);

  // decode the operation; arithmetic wraps modulo 2^XLEN
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD_IMM: alu_result = rs1 + imm;
      ALU_SUB:     alu_result = rs1 - rs2;
      ALU_AND:     alu_result = rs1 & rs2;
      ALU_OR:      alu_result = rs1 | rs2;
      ALU_XOR:     alu_result = rs1 ^ rs2;
      ALU_ADD:     alu_result = rs1 + rs2;
      default:     alu_result = '0;
    endcase
  end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting after last_grant
module rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] last_grant,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           grant_any
);

  // scan last_grant+1, last_grant+2, ... modulo N; first valid candidate wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!grant_any && valid[i] && (i == ((int'(last_grant) + k) % N))) begin
          grant[i]  = 1'b1;
          grant_idx = IDW'(i);
          grant_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one EX ALU between NREQ requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ALU_OP_W-1:0]   req_alu_op,
  input  logic [NREQ*XLEN-1:0]       req_rs1,
  input  logic [NREQ*XLEN-1:0]       req_rs2,
  input  logic [NREQ*XLEN-1:0]       req_imm,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [XLEN-1:0]            rsp_result,
  output logic                       rsp_err
);

  arb_state_e          state;
  logic [IDW-1:0]      last_grant;
  logic [ALU_OP_W-1:0] issue_op;
  logic [XLEN-1:0]     issue_rs1;
  logic [XLEN-1:0]     issue_rs2;
  logic [XLEN-1:0]     issue_imm;
  logic [IDW-1:0]      issue_id;

  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      grant_idx;
  logic                grant_any;
  logic                accept_ok;
  logic                accept;
  logic [ALU_OP_W-1:0] sel_op;
  logic [XLEN-1:0]     sel_rs1;
  logic [XLEN-1:0]     sel_rs2;
  logic [XLEN-1:0]     sel_imm;
  logic [XLEN-1:0]     alu_result;

  rr_pick #(.N(NREQ), .IDW(IDW)) u_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  alu_ex u_alu (
    .alu_op     (issue_op),
    .rs1        (issue_rs1),
    .rs2        (issue_rs2),
    .imm        (issue_imm),
    .alu_result (alu_result)
  );

  // a new request may be taken when idle, or when the pending result drains this cycle
  always_comb begin
    accept_ok = (state == IDLE) || ((state == RESP) && rsp_ready);
    accept    = accept_ok && grant_any;
    req_ready = accept_ok ? grant : '0;
  end

  // one-hot mux of the winning requester's operands
  always_comb begin
    sel_op  = '0;
    sel_rs1 = '0;
    sel_rs2 = '0;
    sel_imm = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op  = req_alu_op[i*ALU_OP_W +: ALU_OP_W];
        sel_rs1 = req_rs1[i*XLEN +: XLEN];
        sel_rs2 = req_rs2[i*XLEN +: XLEN];
        sel_imm = req_imm[i*XLEN +: XLEN];
      end
    end
  end

  // IDLE -> EXEC -> RESP control with registered response and issue capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      issue_op   <= '0;
      issue_rs1  <= '0;
      issue_rs2  <= '0;
      issue_imm  <= '0;
      issue_id   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_err    <= (issue_op > ALU_OP_W'(ALU_OP_LAST));
          rsp_id     <= issue_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        issue_op   <= sel_op;
        issue_rs1  <= sel_rs1;
        issue_rs2  <= sel_rs2;
        issue_imm  <= sel_imm;
        issue_id   <= grant_idx;
        last_grant <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a reference model
module tb_alu_arbiter;

  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*4-1:0]    req_alu_op;
  logic [NREQ*32-1:0]   req_rs1;
  logic [NREQ*32-1:0]   req_rs2;
  logic [NREQ*32-1:0]   req_imm;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [31:0]          rsp_result;
  logic                 rsp_err;

  alu_arbiter #(.NREQ(NREQ), .IDW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_alu_op (req_alu_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  // requester-side stimulus state
  logic [3:0]      op  [NREQ];
  logic [31:0]     rs1 [NREQ];
  logic [31:0]     rs2 [NREQ];
  logic [31:0]     imm [NREQ];
  logic [NREQ-1:0] vld;
  logic [NREQ-1:0] acc;
  int              cnt [NREQ];
  bit              rnd_mode;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] res;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int model_last = NREQ - 1;
  logic        prev_valid, prev_ready, prev_err;
  logic [1:0]  prev_id;
  logic [31:0] prev_res;

  always_comb begin
    req_valid  = vld;
    req_alu_op = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    req_imm    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_alu_op[i*4 +: 4]   = op[i];
      req_rs1[i*32 +: 32]    = rs1[i];
      req_rs2[i*32 +: 32]    = rs2[i];
      req_imm[i*32 +: 32]    = imm[i];
    end
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_alu(logic [3:0] o, logic [31:0] a, logic [31:0] b, logic [31:0] i);
    case (o)
      4'd0:    return a + i;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a + b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_pick(logic [NREQ-1:0] v, int last);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last + k) % NREQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit busy();
    bit b;
    b = (sb.size() != 0) || (acc != '0);
    for (int i = 0; i < NREQ; i++) if (cnt[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic new_ops(input int i);
    if ($urandom_range(0, 3) == 0) op[i] = 4'($urandom_range(6, 15));
    else                           op[i] = 4'($urandom_range(0, 5));
    rs1[i] = $urandom;
    rs2[i] = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
    imm[i] = $urandom;
  endtask

  // requester drivers: react to grants seen by the monitor, just after the clock edge
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        acc[i] = 1'b0;
        if (cnt[i] > 0) cnt[i]--;
        if (cnt[i] == 0) vld[i] = 1'b0;
        else if (rnd_mode) begin
          new_ops(i);
          vld[i] = ($urandom_range(0, 3) != 0);
        end
      end else if (rnd_mode && cnt[i] > 0 && !vld[i] && ($urandom_range(0, 1) == 1)) begin
        vld[i] = 1'b1;
      end
    end
    if (rnd_mode) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  // monitor: accept/grant checks, response pops, hold and latency checks
  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_acc;
      int idx;
      exp_t e;
      cyc++;
      exp_acc = (req_valid != '0) && ((sb.size() == 0) || (rsp_valid && rsp_ready));
      if (exp_acc || (req_ready != '0))
        chk(exp_acc == (req_ready != '0), "accept", 64'(req_ready), 64'(exp_acc));
      if (prev_valid && !prev_ready) begin
        chk(rsp_valid && rsp_id == prev_id && rsp_result == prev_res && rsp_err == prev_err, "rsp_hold",
            64'({rsp_valid, rsp_err, rsp_id, rsp_result}), 64'({1'b1, prev_err, prev_id, prev_res}));
      end else if (rsp_valid) begin
        chk(sb.size() != 0, "rsp_unexpected", 64'(rsp_id), 64'(0));
        if (sb.size() != 0) chk(cyc - sb[0].cyc == 2, "latency", 64'(cyc - sb[0].cyc), 64'(2));
      end
      if (rsp_valid && rsp_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk(rsp_id == e.id, "rsp_id", 64'(rsp_id), 64'(e.id));
        chk(rsp_result == e.res, "rsp_result", 64'(rsp_result), 64'(e.res));
        chk(rsp_err == e.err, "rsp_err", 64'(rsp_err), 64'(e.err));
      end
      prev_valid = rsp_valid;
      prev_ready = rsp_ready;
      prev_id    = rsp_id;
      prev_res   = rsp_result;
      prev_err   = rsp_err;
      if (req_ready != '0) begin
        idx = model_pick(req_valid, model_last);
        if (idx >= 0) begin
          chk(req_ready == NREQ'(1 << idx), "grant", 64'(req_ready), 64'(NREQ'(1 << idx)));
          sb.push_back('{id: 2'(idx), res: model_alu(op[idx], rs1[idx], rs2[idx], imm[idx]),
                         err: (op[idx] > 4'd5), cyc: cyc});
          model_last = idx;
        end
        acc = acc | req_ready;
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while (busy() && n < 2000) begin
      @(posedge clk); #2;
      n++;
    end
    chk(n < 2000, {"drain_", name}, 64'(sb.size()), 64'(0));
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic wait_rsp_valid(input string name);
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk(rsp_valid == 1'b1, {"wait_", name}, 64'(rsp_valid), 64'(1));
  endtask

  task automatic reset_clean();
    sb.delete();
    acc        = '0;
    model_last = NREQ - 1;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    rsp_ready  = 1'b1;
    rnd_mode   = 1'b0;
    vld        = '0;
    acc        = '0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op[i] = '0; rs1[i] = '0; rs2[i] = '0; imm[i] = '0; cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk(rsp_valid == 1'b0, "reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk(req_ready == '0, "reset_req_ready", 64'(req_ready), 64'(0));
    chk(rsp_id == '0, "reset_rsp_id", 64'(rsp_id), 64'(0));
    chk(rsp_result == '0, "reset_rsp_result", 64'(rsp_result), 64'(0));
    chk(rsp_err == 1'b0, "reset_rsp_err", 64'(rsp_err), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #2;

    // single request: 5 + 7
    op[0] = 4'd0; rs1[0] = 32'd5; rs2[0] = 32'd99; imm[0] = 32'd7;
    cnt[0] = 1; vld[0] = 1'b1;
    drain("single");

    // contention between two held requesters
    op[0] = 4'd1; rs1[0] = 32'd10; rs2[0] = 32'd3; imm[0] = 32'd0;
    op[1] = 4'd5; rs1[1] = 32'd1;  rs2[1] = 32'd2; imm[1] = 32'd0;
    cnt[0] = 2; cnt[1] = 2; vld[0] = 1'b1; vld[1] = 1'b1;
    drain("contention");

    // wrap and illegal op
    op[1] = 4'd1; rs1[1] = 32'd0; rs2[1] = 32'd1; imm[1] = 32'd0;
    op[2] = 4'd9; rs1[2] = 32'd123; rs2[2] = 32'd456; imm[2] = 32'd789;
    cnt[1] = 1; cnt[2] = 1; vld[1] = 1'b1; vld[2] = 1'b1;
    drain("wrap_illegal");

    // backpressure: hold RESP for 5 cycles with another request pending
    rsp_ready = 1'b0;
    op[2] = 4'd2; rs1[2] = 32'hF0F0_1234; rs2[2] = 32'h0FF0_FFFF;
    cnt[2] = 1; vld[2] = 1'b1;
    wait_rsp_valid("bp");
    op[3] = 4'd4; rs1[3] = 32'hAAAA_5555; rs2[3] = 32'h1234_5678;
    cnt[3] = 1; vld[3] = 1'b1;
    repeat (5) begin
      @(posedge clk); #2;
      chk(req_ready == '0, "bp_req_ready", 64'(req_ready), 64'(0));
      chk(rsp_valid == 1'b1, "bp_rsp_valid", 64'(rsp_valid), 64'(1));
    end
    rsp_ready = 1'b1;
    #1;
    chk(req_ready == 4'b1000, "bp_release_grant", 64'(req_ready), 64'(4'b1000));
    drain("backpressure");

    // reset while the operation is in EXEC
    op[0] = 4'd4; rs1[0] = 32'h1111_0000; rs2[0] = 32'h0000_2222;
    cnt[0] = 1; vld[0] = 1'b1;
    n = 0;
    while (sb.size() == 0 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk(sb.size() != 0, "exec_reset_accept", 64'(sb.size()), 64'(1));
    rst_n = 1'b0;
    #1;
    chk(rsp_valid == 1'b0, "exec_reset_rsp_valid", 64'(rsp_valid), 64'(0));
    reset_clean();
    repeat (2) @(posedge clk);
    #2;
    op[0] = 4'd5; rs1[0] = 32'd40; rs2[0] = 32'd2;
    op[1] = 4'd3; rs1[1] = 32'h00F0; rs2[1] = 32'h0F00;
    cnt[0] = 1; cnt[1] = 1;
    rst_n = 1'b1;
    vld[0] = 1'b1; vld[1] = 1'b1;
    #1;
    chk(req_ready == 4'b0001, "post_reset_first_grant", 64'(req_ready), 64'(4'b0001));
    drain("exec_reset");

    // reset while a response is held in RESP
    rsp_ready = 1'b0;
    op[2] = 4'd1; rs1[2] = 32'd7; rs2[2] = 32'd9;
    cnt[2] = 1; vld[2] = 1'b1;
    wait_rsp_valid("resp_reset");
    rst_n = 1'b0;
    #1;
    chk(rsp_valid == 1'b0, "resp_reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk(rsp_result == '0, "resp_reset_rsp_result", 64'(rsp_result), 64'(0));
    reset_clean();
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // all four requesters valid and held
    for (int i = 0; i < NREQ; i++) begin
      op[i] = 4'(i + 1); rs1[i] = 32'(100 * (i + 1)); rs2[i] = 32'(i + 3); imm[i] = 32'(i);
      cnt[i] = 2;
    end
    vld = '1;
    drain("all_valid");

    // randomized traffic with random backpressure
    for (int i = 0; i < NREQ; i++) begin
      new_ops(i);
      cnt[i] = 12;
    end
    rnd_mode = 1'b1;
    vld = '1;
    drain("random");
    rnd_mode = 1'b0;
    rsp_ready = 1'b1;
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
